// File: rtl/dispatch_pkg.sv
// Shared definitions for the patient dispatcher: query codes sent to the
// allotment block, the message codes it returns, and the dispatcher FSM states.
package dispatch_pkg;

   // Query codes presented on `query`
   localparam logic [1:0] Q_A_ONLY = 2'b00;
   localparam logic [1:0] Q_ANY0   = 2'b01;
   localparam logic [1:0] Q_ANY1   = 2'b10;
   localparam logic [1:0] Q_B_ONLY = 2'b11;

   // Message codes returned by the allotment block
   localparam logic [1:0] MSG_A    = 2'b01;
   localparam logic [1:0] MSG_B    = 2'b10;
   localparam logic [1:0] MSG_BUSY = 2'b11;

   // done_doctor value for a check-in that exhausted its retries
   localparam logic [1:0] DOC_FAILED = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StStrbHi,
      StStrbLo,
      StSample,
      StBackoff,
      StReport
   } state_t;

   // Only 01 and 10 name a doctor; 11 is busy and 00 is an allocator that
   // has not produced a response yet.
   function automatic logic msg_is_doctor(input logic [1:0] msg);
      return (msg == MSG_A) || (msg == MSG_B);
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Small synchronous FIFO holding pending check-ins.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   push, wdata      - write request and data (ignored when full)
//   pop              - read request (ignored when empty); rdata shows the head
//   full, empty      - derived from the registered occupancy count
//   count            - number of entries held
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module dispatch_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   // full/empty come from the registered count, so a pop cannot open space
   // for a push within the same cycle.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/patient_dispatcher.sv
// Front-end requester for the doctor-allotment handshake. Check-ins are queued
// in a FIFO and issued one at a time: query is driven, start is pulsed for one
// cycle, and the returned message is sampled two cycles later. Busy responses
// are retried after RETRY_GAP idle cycles, up to MAX_RETRY busy responses.
// Every accepted check-in yields one done_valid pulse.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   pat_valid/pat_ready          - check-in handshake, pat_id/pat_query payload
//   query, start                 - request to the allotment block
//   message                      - allotment response (01 A, 10 B, 11 busy)
//   done_valid/done_id/done_doctor - result pulse (done_doctor 11 = failed)
// Optional feature (macro DISPATCH_STATS_EN): stat_served / stat_failed,
// saturating 16-bit counts of successful and failed reports.
module patient_dispatcher
   import dispatch_pkg::*;
#(
   parameter int unsigned ID_W      = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned RETRY_GAP = 16,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pat_valid,
   output logic            pat_ready,
   input  logic [ID_W-1:0] pat_id,
   input  logic [1:0]      pat_query,
   output logic [1:0]      query,
   output logic            start,
   input  logic [1:0]      message,
   output logic            done_valid,
   output logic [ID_W-1:0] done_id,
   output logic [1:0]      done_doctor
`ifdef DISPATCH_STATS_EN
   ,
   output logic [15:0]     stat_served,
   output logic [15:0]     stat_failed
`endif
);

   localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   state_t              state;
   logic [ID_W-1:0]     cur_id;
   logic [1:0]          cur_query;
   logic [RW-1:0]       retry_cnt;
   logic [GW-1:0]       gap_cnt;

   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ID_W+1:0]     fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                unused_count;

   assign pat_ready    = ~fifo_full;
   assign fifo_pop     = (state == StIdle) & ~fifo_empty;
   assign unused_count = ^fifo_count;

   // cur_query is cleared when leaving SAMPLE for REPORT, so it is the
   // registered query output: held from STRB_HI through BACKOFF, else 00.
   assign query = cur_query;

   dispatch_fifo #(
      .WIDTH (ID_W + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pat_valid),
      .wdata ({pat_id, pat_query}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         cur_id      <= '0;
         cur_query   <= Q_A_ONLY;
         retry_cnt   <= '0;
         gap_cnt     <= '0;
         start       <= 1'b0;
         done_valid  <= 1'b0;
         done_id     <= '0;
         done_doctor <= 2'b00;
      end else begin
         start      <= 1'b0;
         done_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (!fifo_empty) begin
                  cur_id    <= fifo_head[ID_W+1:2];
                  cur_query <= fifo_head[1:0];
                  retry_cnt <= '0;
                  start     <= 1'b1;
                  state     <= StStrbHi;
               end
            end
            StStrbHi: state <= StStrbLo;
            StStrbLo: state <= StSample;
            StSample: begin
               if (msg_is_doctor(message)) begin
                  done_valid  <= 1'b1;
                  done_id     <= cur_id;
                  done_doctor <= message;
                  cur_query   <= Q_A_ONLY;
                  state       <= StReport;
               end else if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                  done_valid  <= 1'b1;
                  done_id     <= cur_id;
                  done_doctor <= DOC_FAILED;
                  cur_query   <= Q_A_ONLY;
                  state       <= StReport;
               end else begin
                  retry_cnt <= retry_cnt + 1'b1;
                  gap_cnt   <= '0;
                  state     <= StBackoff;
               end
            end
            StBackoff: begin
               if (gap_cnt == GW'(RETRY_GAP - 1)) begin
                  start <= 1'b1;
                  state <= StStrbHi;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            StReport: state <= StIdle;
            default:  state <= StIdle;
         endcase
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_served <= '0;
         stat_failed <= '0;
      end else if (state == StReport) begin
         if (done_doctor == DOC_FAILED) begin
            if (stat_failed != 16'hFFFF) stat_failed <= stat_failed + 16'd1;
         end else begin
            if (stat_served != 16'hFFFF) stat_served <= stat_served + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_patient_dispatcher.sv
// Self-checking bench for patient_dispatcher with a behavioural allotment
// block: each doctor stays occupied for 15 cycles after a booking, and the
// response is updated on the falling edge of start. Expected results are
// queued when a check-in is pushed and popped when done_valid appears.
module tb_patient_dispatcher;
   import dispatch_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       pat_valid;
   logic       pat_ready;
   logic [7:0] pat_id;
   logic [1:0] pat_query;
   logic [1:0] query;
   logic       start;
   logic [1:0] message = 2'b00;
   logic       done_valid;
   logic [7:0] done_id;
   logic [1:0] done_doctor;
`ifdef DISPATCH_STATS_EN
   logic [15:0] stat_served;
   logic [15:0] stat_failed;
`endif

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] doc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   patient_dispatcher #(
      .ID_W      (8),
      .DEPTH     (4),
      .RETRY_GAP (16),
      .MAX_RETRY (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pat_valid   (pat_valid),
      .pat_ready   (pat_ready),
      .pat_id      (pat_id),
      .pat_query   (pat_query),
      .query       (query),
      .start       (start),
      .message     (message),
      .done_valid  (done_valid),
      .done_id     (done_id),
      .done_doctor (done_doctor)
`ifdef DISPATCH_STATS_EN
      ,
      .stat_served (stat_served),
      .stat_failed (stat_failed)
`endif
   );

   // Allotment block model
   logic always_busy = 1'b0;
   logic start_d = 1'b0;
   int   busy_a = 0;
   int   busy_b = 0;

   always @(posedge clk) begin
      start_d <= start;
      if (busy_a > 0) busy_a <= busy_a - 1;
      if (busy_b > 0) busy_b <= busy_b - 1;
      if (start_d && !start) begin
         if (always_busy) begin
            message <= MSG_BUSY;
         end else if (query == Q_A_ONLY) begin
            if (busy_a == 0) begin message <= MSG_A; busy_a <= 15; end
            else message <= MSG_BUSY;
         end else if (query == Q_B_ONLY) begin
            if (busy_b == 0) begin message <= MSG_B; busy_b <= 15; end
            else message <= MSG_BUSY;
         end else begin
            if (busy_a == 0) begin message <= MSG_A; busy_a <= 15; end
            else if (busy_b == 0) begin message <= MSG_B; busy_b <= 15; end
            else message <= MSG_BUSY;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] id, input logic [1:0] q, input logic [1:0] doc);
      pat_valid = 1'b1;
      pat_id    = id;
      pat_query = q;
      for (int i = 0; i < 400 && !pat_ready; i++) step();
      if (!pat_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: id %h got pat_ready %b want 1", id, pat_ready);
      end
      sb.push_back({id, doc});
      step();
      pat_valid = 1'b0;
   endtask

   task automatic collect_done(input int max_cyc, output logic got, output logic [7:0] id,
                               output logic [1:0] doc);
      got = 1'b0; id = '0; doc = '0;
      for (int i = 0; i < max_cyc; i++) begin
         step();
         if (done_valid) begin
            got = 1'b1; id = done_id; doc = done_doctor;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_cmp++; if (pat_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", pat_ready); end
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", start); end
      n_cmp++; if (query !== 2'b00) begin n_bad++; $display("FAIL reset_query: got %b want 00", query); end
      n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
      n_cmp++; if (done_id !== 8'h00) begin n_bad++; $display("FAIL reset_done_id: got %h want 00", done_id); end
      n_cmp++; if (done_doctor !== 2'b00) begin n_bad++; $display("FAIL reset_done_doctor: got %b want 00", done_doctor); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      exp_t e;
      push_one(8'h11, Q_A_ONLY, MSG_A);
      // now in cycle 1 after the accepting edge
      for (int c = 1; c <= 6; c++) begin
         n_cmp++;
         if (start !== (c == 2)) begin
            n_bad++; $display("FAIL single_start c%0d: got %b want %b", c, start, (c == 2));
         end
         n_cmp++;
         if (done_valid !== (c == 5)) begin
            n_bad++; $display("FAIL single_done_valid c%0d: got %b want %b", c, done_valid, (c == 5));
         end
         if (c == 5) begin
            e = sb.pop_front();
            n_cmp++;
            if (done_id !== e.id || done_doctor !== e.doc) begin
               n_bad++;
               $display("FAIL single_result: got id %h doc %b want id %h doc %b",
                        done_id, done_doctor, e.id, e.doc);
            end
         end
         step();
      end
   endtask

   task automatic test_routing();
      exp_t e; logic got; logic [7:0] id; logic [1:0] doc;
      repeat (20) step();
      push_one(8'h01, Q_ANY0, MSG_A);
      push_one(8'h02, Q_ANY0, MSG_B);
      push_one(8'h03, Q_ANY0, MSG_A);
      for (int k = 0; k < 3; k++) begin
         collect_done(100, got, id, doc);
         e = sb.pop_front();
         n_cmp++;
         if (!got || id !== e.id || doc !== e.doc) begin
            n_bad++;
            $display("FAIL routing_done%0d: got id %h doc %b seen %b want id %h doc %b",
                     k, id, doc, got, e.id, e.doc);
         end
      end
   endtask

   task automatic test_failure();
      exp_t e; int c; int ns; int st[3]; int dc;
      logic got; logic [7:0] did; logic [1:0] ddoc;
      always_busy = 1'b1;
      push_one(8'h44, Q_B_ONLY, DOC_FAILED);
      c = 1; ns = 0; st = '{0, 0, 0}; dc = 0; got = 1'b0; did = '0; ddoc = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         if (start) begin
            if (ns < 3) st[ns] = c;
            ns++;
            n_cmp++;
            if (query !== Q_B_ONLY) begin n_bad++; $display("FAIL fail_query: got %b want 11", query); end
         end
         if (done_valid) begin
            got = 1'b1; dc = c; did = done_id; ddoc = done_doctor;
         end else begin
            step(); c++;
         end
      end
      n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL fail_strobes: got %0d want 3", ns); end
      n_cmp++; if (st[0] !== 2) begin n_bad++; $display("FAIL fail_first_strobe: got %0d want 2", st[0]); end
      n_cmp++; if (st[1] - st[0] !== 19) begin n_bad++; $display("FAIL fail_gap1: got %0d want 19", st[1] - st[0]); end
      n_cmp++; if (st[2] - st[1] !== 19) begin n_bad++; $display("FAIL fail_gap2: got %0d want 19", st[2] - st[1]); end
      n_cmp++; if (dc - st[2] !== 3) begin n_bad++; $display("FAIL fail_report_lat: got %0d want 3", dc - st[2]); end
      e = sb.pop_front();
      n_cmp++;
      if (!got || did !== e.id || ddoc !== e.doc) begin
         n_bad++;
         $display("FAIL fail_result: got id %h doc %b seen %b want id %h doc %b", did, ddoc, got, e.id, e.doc);
      end
      step();
   endtask

   task automatic test_fifo_full();
      exp_t e; int acc; int dones; logic chk_full;
      logic got; logic [7:0] id; logic [1:0] doc;
      always_busy = 1'b1;
      push_one(8'hA0, Q_A_ONLY, DOC_FAILED);
      for (int i = 0; i < 10 && !start; i++) step();
      acc = 0; dones = 0; chk_full = 1'b0;
      pat_valid = 1'b1; pat_query = Q_A_ONLY; pat_id = 8'hB1;
      for (int i = 0; i < 300 && acc < 5; i++) begin
         if (done_valid) begin
            dones++;
            e = sb.pop_front();
            n_cmp++;
            if (done_id !== e.id || done_doctor !== e.doc) begin
               n_bad++;
               $display("FAIL fifo_blocker_done: got id %h doc %b want id %h doc %b",
                        done_id, done_doctor, e.id, e.doc);
            end
         end
         if (acc == 4 && !chk_full) begin
            chk_full = 1'b1;
            n_cmp++;
            if (pat_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_full_ready: got %b want 0", pat_ready); end
         end
         if (pat_ready) begin
            if (acc == 4) begin
               n_cmp++;
               if (dones !== 1) begin n_bad++; $display("FAIL fifo_fifth_after_pop: got dones %0d want 1", dones); end
            end
            sb.push_back({pat_id, DOC_FAILED});
            acc++;
         end
         step();
         pat_id = 8'hB1 + 8'(acc);
      end
      pat_valid = 1'b0;
      n_cmp++; if (acc !== 5) begin n_bad++; $display("FAIL fifo_accepts: got %0d want 5", acc); end
      for (int k = 0; k < 5; k++) begin
         collect_done(100, got, id, doc);
         e = sb.pop_front();
         n_cmp++;
         if (!got || id !== e.id || doc !== e.doc) begin
            n_bad++;
            $display("FAIL fifo_order%0d: got id %h doc %b seen %b want id %h doc %b",
                     k, id, doc, got, e.id, e.doc);
         end
      end
      always_busy = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int starts; int dones;
      repeat (20) step();
      push_one(8'h61, Q_A_ONLY, MSG_A);
      push_one(8'h62, Q_B_ONLY, MSG_B);
      for (int i = 0; i < 10 && !start; i++) step();
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL mid_strobe_seen: got %b want 1", start); end
      rst = 1'b1;
      step();
      sb.delete();
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL mid_start: got %b want 0", start); end
      n_cmp++; if (pat_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", pat_ready); end
      n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done_valid); end
      rst = 1'b0;
      starts = 0; dones = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (start) starts++;
         if (done_valid) dones++;
      end
      n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL mid_flush_starts: got %0d want 0", starts); end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_flush_dones: got %0d want 0", dones); end
   endtask

`ifdef DISPATCH_STATS_EN
   task automatic test_stats();
      exp_t e; logic got; logic [7:0] id; logic [1:0] doc;
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (20) step();
      n_cmp++; if (stat_served !== 16'd0) begin n_bad++; $display("FAIL stats_reset_served: got %0d want 0", stat_served); end
      n_cmp++; if (stat_failed !== 16'd0) begin n_bad++; $display("FAIL stats_reset_failed: got %0d want 0", stat_failed); end
      always_busy = 1'b0;
      push_one(8'h71, Q_A_ONLY, MSG_A);
      push_one(8'h72, Q_B_ONLY, MSG_B);
      for (int k = 0; k < 2; k++) begin
         collect_done(100, got, id, doc);
         e = sb.pop_front();
         n_cmp++;
         if (!got || id !== e.id || doc !== e.doc) begin
            n_bad++; $display("FAIL stats_ok%0d: got id %h doc %b want id %h doc %b", k, id, doc, e.id, e.doc);
         end
      end
      always_busy = 1'b1;
      push_one(8'h73, Q_A_ONLY, DOC_FAILED);
      collect_done(100, got, id, doc);
      e = sb.pop_front();
      n_cmp++;
      if (!got || id !== e.id || doc !== e.doc) begin
         n_bad++; $display("FAIL stats_fail_done: got id %h doc %b want id %h doc %b", id, doc, e.id, e.doc);
      end
      repeat (2) step();
      n_cmp++; if (stat_served !== 16'd2) begin n_bad++; $display("FAIL stats_served: got %0d want 2", stat_served); end
      n_cmp++; if (stat_failed !== 16'd1) begin n_bad++; $display("FAIL stats_failed: got %0d want 1", stat_failed); end
      always_busy = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; pat_valid = 1'b0; pat_id = '0; pat_query = '0;
      test_reset();
      test_single();
      test_routing();
      test_failure();
      test_fifo_full();
      test_reset_mid();
`ifdef DISPATCH_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
